// File: rtl/key_cmd_sequencer_if.sv
// Signal bundle between the keypad scanner, the key/command sequencer and
// the motion controller / display logic.
interface key_cmd_sequencer_if;
   logic       key_flag;
   logic [9:0] key_num;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [2:0] cmd_op;
   logic [6:0] cmd_arg;
   logic [6:0] entry_val;
   logic       entering;
   logic       err;

   // The sequencer side: consumes key strobes, produces commands and feedback
   modport master (
      input  key_flag,
      input  key_num,
      input  cmd_ready,
      output cmd_valid,
      output cmd_op,
      output cmd_arg,
      output entry_val,
      output entering,
      output err
   );

   // The environment side: scanner, motion controller and display
   modport slave (
      output key_flag,
      output key_num,
      output cmd_ready,
      input  cmd_valid,
      input  cmd_op,
      input  cmd_arg,
      input  entry_val,
      input  entering,
      input  err
   );
endinterface

// File: rtl/key_cmd_sequencer.sv
// Keypad command sequencer: turns one-cycle key strobes into motion/speed
// commands over a valid/ready handshake, assembles multi-digit speed entry,
// buffers one key while a command is stalled, and flags errors/timeouts.
module key_cmd_sequencer #(
   parameter int TICK_DIV   = 50,
   parameter int TIMEOUT_MS = 2000,
   parameter int DIGITS_MAX = 2,
   parameter int SPEED_MAX  = 99
) (
   input logic                 clk_M,
   input logic                 reset,
   key_cmd_sequencer_if.master bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ENTRY = 2'd1,
      ISSUE = 2'd2
   } state_t;

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int MW = $clog2(TIMEOUT_MS + 1);

   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
   localparam logic [MW-1:0] MS_LAST    = MW'(TIMEOUT_MS - 1);
   localparam logic [1:0]    DIGITS_LIM = 2'(DIGITS_MAX);
   localparam logic [6:0]    SPEED_LIM  = 7'(SPEED_MAX);
   localparam logic [6:0]    TEN        = 7'd10;

   localparam logic [2:0] OP_FWD   = 3'd1;
   localparam logic [2:0] OP_BWD   = 3'd2;
   localparam logic [2:0] OP_LEFT  = 3'd3;
   localparam logic [2:0] OP_RIGHT = 3'd4;
   localparam logic [2:0] OP_STOP  = 3'd5;
   localparam logic [2:0] OP_SPEED = 3'd6;

   localparam logic [3:0] KEY_STOP  = 4'd14;
   localparam logic [3:0] KEY_ENTER = 4'd15;

   state_t          state;
   logic            cmd_valid_q;
   logic [2:0]      cmd_op_q;
   logic [6:0]      cmd_arg_q;
   logic [6:0]      entry_q;
   logic [1:0]      digit_cnt;
   logic            err_q;
   logic            pend_valid;
   logic [3:0]      pend_code;
   logic [PW-1:0]   presc;
   logic [MW-1:0]   ms_cnt;

   logic            live_ok;
   logic [3:0]      live_code;
   logic            eff_ok;
   logic [3:0]      eff_code;
   logic            eff_digit;
   logic            store_live;
   logic            tick_wrap;
   logic            time_up;
   logic            entry_accept;

   assign bus.cmd_valid = cmd_valid_q;
   assign bus.cmd_op    = cmd_op_q;
   assign bus.cmd_arg   = cmd_arg_q;
   assign bus.entry_val = entry_q;
   assign bus.entering  = (state == ENTRY);
   assign bus.err       = err_q;

   // Pick the key to act on this cycle (a buffered key wins over the live
   // strobe outside ISSUE) and decide whether the live strobe must be
   // parked in the pending buffer instead.
   always_comb begin
      live_ok      = bus.key_flag && (bus.key_num < 10'd16);
      live_code    = bus.key_num[3:0];
      eff_ok       = (state != ISSUE) && (pend_valid || live_ok);
      eff_code     = pend_valid ? pend_code : live_code;
      eff_digit    = (eff_code < 4'd10);
      store_live   = live_ok && ((state == ISSUE) || pend_valid);
      tick_wrap    = (presc == PRESC_LAST);
      time_up      = tick_wrap && (ms_cnt == MS_LAST);
      entry_accept = eff_ok && ((eff_digit && (digit_cnt < DIGITS_LIM)) || (eff_code >= KEY_STOP));
   end

   // Main sequencer: state, registered outputs, pending buffer and timeout counters
   always_ff @(posedge clk_M) begin
      if (reset) begin
         state       <= IDLE;
         cmd_valid_q <= 1'b0;
         cmd_op_q    <= 3'd0;
         cmd_arg_q   <= 7'd0;
         entry_q     <= 7'd0;
         digit_cnt   <= 2'd0;
         err_q       <= 1'b0;
         pend_valid  <= 1'b0;
         pend_code   <= 4'd0;
         presc       <= '0;
         ms_cnt      <= '0;
      end else begin
         err_q <= 1'b0;

         if ((state != ISSUE) && pend_valid) begin
            pend_valid <= 1'b0;
         end

         if (store_live) begin
            if ((state == ISSUE) && pend_valid) begin
               if (live_code == KEY_STOP) begin
                  pend_code <= live_code;
               end else begin
                  err_q <= 1'b1;
               end
            end else begin
               pend_valid <= 1'b1;
               pend_code  <= live_code;
            end
         end

         case (state)
            IDLE: begin
               if (eff_ok) begin
                  if (eff_digit) begin
                     entry_q   <= {3'b000, eff_code};
                     digit_cnt <= 2'd1;
                     presc     <= '0;
                     ms_cnt    <= '0;
                     state     <= ENTRY;
                  end else if (eff_code == KEY_ENTER) begin
                     err_q <= 1'b1;
                  end else begin
                     cmd_valid_q <= 1'b1;
                     cmd_arg_q   <= 7'd0;
                     state       <= ISSUE;
                     case (eff_code)
                        4'd10:   cmd_op_q <= OP_FWD;
                        4'd11:   cmd_op_q <= OP_BWD;
                        4'd12:   cmd_op_q <= OP_LEFT;
                        4'd13:   cmd_op_q <= OP_RIGHT;
                        default: cmd_op_q <= OP_STOP;
                     endcase
                  end
               end
            end

            ENTRY: begin
               if (entry_accept) begin
                  if (eff_digit) begin
                     entry_q   <= (entry_q * TEN) + {3'b000, eff_code};
                     digit_cnt <= digit_cnt + 2'd1;
                     presc     <= '0;
                     ms_cnt    <= '0;
                  end else begin
                     entry_q   <= 7'd0;
                     digit_cnt <= 2'd0;
                     presc     <= '0;
                     ms_cnt    <= '0;
                     if (eff_code == KEY_STOP) begin
                        cmd_valid_q <= 1'b1;
                        cmd_op_q    <= OP_STOP;
                        cmd_arg_q   <= 7'd0;
                        state       <= ISSUE;
                     end else if (entry_q <= SPEED_LIM) begin
                        cmd_valid_q <= 1'b1;
                        cmd_op_q    <= OP_SPEED;
                        cmd_arg_q   <= entry_q;
                        state       <= ISSUE;
                     end else begin
                        err_q <= 1'b1;
                        state <= IDLE;
                     end
                  end
               end else begin
                  if (eff_ok) begin
                     err_q <= 1'b1;
                  end
                  if (time_up) begin
                     err_q     <= 1'b1;
                     state     <= IDLE;
                     entry_q   <= 7'd0;
                     digit_cnt <= 2'd0;
                     presc     <= '0;
                     ms_cnt    <= '0;
                  end else if (tick_wrap) begin
                     presc  <= '0;
                     ms_cnt <= ms_cnt + 1'b1;
                  end else begin
                     presc <= presc + 1'b1;
                  end
               end
            end

            ISSUE: begin
               if (bus.cmd_ready) begin
                  cmd_valid_q <= 1'b0;
                  cmd_op_q    <= 3'd0;
                  cmd_arg_q   <= 7'd0;
                  state       <= IDLE;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_key_cmd_sequencer.sv
// Directed bench for key_cmd_sequencer: short timing parameters, one task
// per scenario, expected values worked out by hand from the key map.
module tb_key_cmd_sequencer;

   logic clk_M = 1'b0;
   logic reset;
   int   checks   = 0;
   int   failures = 0;

   key_cmd_sequencer_if bus ();
   key_cmd_sequencer_if bus50 ();

   key_cmd_sequencer #(
      .TICK_DIV(4), .TIMEOUT_MS(5), .DIGITS_MAX(2), .SPEED_MAX(99)
   ) dut (
      .clk_M(clk_M), .reset(reset), .bus(bus)
   );

   key_cmd_sequencer #(
      .TICK_DIV(4), .TIMEOUT_MS(5), .DIGITS_MAX(2), .SPEED_MAX(50)
   ) dut50 (
      .clk_M(clk_M), .reset(reset), .bus(bus50)
   );

   // Free-running 10-time-unit clock
   always #5 clk_M = ~clk_M;

   // Advance one active edge, then settle so outputs are sampled away from it
   task automatic cycle();
      @(posedge clk_M);
      #1;
   endtask

   // One-cycle key strobe on either instance; outputs are valid on return
   task automatic applyStimulus(input logic [9:0] k, input bit on50);
      if (on50) begin
         bus50.key_flag = 1'b1;
         bus50.key_num  = k;
      end else begin
         bus.key_flag = 1'b1;
         bus.key_num  = k;
      end
      cycle();
      bus.key_flag   = 1'b0;
      bus.key_num    = 10'd0;
      bus50.key_flag = 1'b0;
      bus50.key_num  = 10'd0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      cycle();
      cycle();
      checks++; if (bus.cmd_valid !== 1'b0) begin failures++;
         $display("[TB] FAIL reset cmd_valid: got %0d want 0", bus.cmd_valid); end
      checks++; if (bus.cmd_op !== 3'd0) begin failures++;
         $display("[TB] FAIL reset cmd_op: got %0d want 0", bus.cmd_op); end
      checks++; if (bus.cmd_arg !== 7'd0) begin failures++;
         $display("[TB] FAIL reset cmd_arg: got %0d want 0", bus.cmd_arg); end
      checks++; if (bus.entry_val !== 7'd0) begin failures++;
         $display("[TB] FAIL reset entry_val: got %0d want 0", bus.entry_val); end
      checks++; if (bus.entering !== 1'b0) begin failures++;
         $display("[TB] FAIL reset entering: got %0d want 0", bus.entering); end
      checks++; if (bus.err !== 1'b0) begin failures++;
         $display("[TB] FAIL reset err: got %0d want 0", bus.err); end
      reset = 1'b0;
      cycle();
   endtask

   task automatic test_speed_entry();
      applyStimulus(10'd4, 1'b0);
      checks++; if (bus.entering !== 1'b1) begin failures++;
         $display("[TB] FAIL speed entering: got %0d want 1", bus.entering); end
      checks++; if (bus.entry_val !== 7'd4) begin failures++;
         $display("[TB] FAIL speed entry_val4: got %0d want 4", bus.entry_val); end
      applyStimulus(10'd5, 1'b0);
      checks++; if (bus.entry_val !== 7'd45) begin failures++;
         $display("[TB] FAIL speed entry_val45: got %0d want 45", bus.entry_val); end
      bus.cmd_ready = 1'b0;
      applyStimulus(10'd15, 1'b0);
      checks++; if (bus.entering !== 1'b0 || bus.entry_val !== 7'd0) begin failures++;
         $display("[TB] FAIL speed leave_entry: got entering=%0d entry_val=%0d want 0/0", bus.entering, bus.entry_val); end
      for (int i = 0; i < 3; i++) begin
         checks++; if (bus.cmd_valid !== 1'b1 || bus.cmd_op !== 3'd6 || bus.cmd_arg !== 7'd45) begin failures++;
            $display("[TB] FAIL speed stall%0d: got valid=%0d op=%0d arg=%0d want 1/6/45", i, bus.cmd_valid, bus.cmd_op, bus.cmd_arg); end
         cycle();
      end
      bus.cmd_ready = 1'b1;
      cycle();
      checks++; if (bus.cmd_valid !== 1'b0 || bus.cmd_op !== 3'd0 || bus.cmd_arg !== 7'd0) begin failures++;
         $display("[TB] FAIL speed handshake: got valid=%0d op=%0d arg=%0d want 0/0/0", bus.cmd_valid, bus.cmd_op, bus.cmd_arg); end
   endtask

   task automatic test_motion_keys();
      applyStimulus(10'd10, 1'b0);
      checks++; if (bus.cmd_valid !== 1'b1 || bus.cmd_op !== 3'd1 || bus.cmd_arg !== 7'd0) begin failures++;
         $display("[TB] FAIL fwd issue: got valid=%0d op=%0d arg=%0d want 1/1/0", bus.cmd_valid, bus.cmd_op, bus.cmd_arg); end
      cycle();
      checks++; if (bus.cmd_valid !== 1'b0) begin failures++;
         $display("[TB] FAIL fwd drop: got %0d want 0", bus.cmd_valid); end
      applyStimulus(10'd15, 1'b0);
      checks++; if (bus.err !== 1'b1 || bus.entering !== 1'b0 || bus.cmd_valid !== 1'b0) begin failures++;
         $display("[TB] FAIL idle_enter: got err=%0d entering=%0d valid=%0d want 1/0/0", bus.err, bus.entering, bus.cmd_valid); end
      applyStimulus(10'd20, 1'b0);
      checks++; if (bus.err !== 1'b0 || bus.entering !== 1'b0 || bus.cmd_valid !== 1'b0) begin failures++;
         $display("[TB] FAIL bad_code: got err=%0d entering=%0d valid=%0d want 0/0/0", bus.err, bus.entering, bus.cmd_valid); end
   endtask

   task automatic test_digit_limit();
      applyStimulus(10'd1, 1'b0);
      applyStimulus(10'd2, 1'b0);
      checks++; if (bus.entry_val !== 7'd12 || bus.err !== 1'b0) begin failures++;
         $display("[TB] FAIL digits twelve: got entry_val=%0d err=%0d want 12/0", bus.entry_val, bus.err); end
      applyStimulus(10'd3, 1'b0);
      checks++; if (bus.err !== 1'b1 || bus.entry_val !== 7'd12) begin failures++;
         $display("[TB] FAIL digits third: got err=%0d entry_val=%0d want 1/12", bus.err, bus.entry_val); end
      cycle();
      checks++; if (bus.err !== 1'b0 || bus.entering !== 1'b1) begin failures++;
         $display("[TB] FAIL digits pulse: got err=%0d entering=%0d want 0/1", bus.err, bus.entering); end
      applyStimulus(10'd15, 1'b0);
      checks++; if (bus.cmd_valid !== 1'b1 || bus.cmd_op !== 3'd6 || bus.cmd_arg !== 7'd12) begin failures++;
         $display("[TB] FAIL digits speed: got valid=%0d op=%0d arg=%0d want 1/6/12", bus.cmd_valid, bus.cmd_op, bus.cmd_arg); end
      cycle();
      checks++; if (bus.cmd_valid !== 1'b0) begin failures++;
         $display("[TB] FAIL digits drop: got %0d want 0", bus.cmd_valid); end
   endtask

   task automatic test_speed_max();
      applyStimulus(10'd6, 1'b1);
      applyStimulus(10'd0, 1'b1);
      checks++; if (bus50.entry_val !== 7'd60) begin failures++;
         $display("[TB] FAIL max entry_val: got %0d want 60", bus50.entry_val); end
      applyStimulus(10'd15, 1'b1);
      checks++; if (bus50.err !== 1'b1 || bus50.cmd_valid !== 1'b0 || bus50.entering !== 1'b0 || bus50.entry_val !== 7'd0) begin failures++;
         $display("[TB] FAIL max reject: got err=%0d valid=%0d entering=%0d entry_val=%0d want 1/0/0/0", bus50.err, bus50.cmd_valid, bus50.entering, bus50.entry_val); end
      cycle();
      checks++; if (bus50.cmd_valid !== 1'b0 || bus50.err !== 1'b0) begin failures++;
         $display("[TB] FAIL max after: got valid=%0d err=%0d want 0/0", bus50.cmd_valid, bus50.err); end
   endtask

   task automatic test_timeout();
      applyStimulus(10'd7, 1'b0);
      for (int i = 0; i < 19; i++) begin
         cycle();
      end
      checks++; if (bus.entering !== 1'b1 || bus.err !== 1'b0 || bus.entry_val !== 7'd7) begin failures++;
         $display("[TB] FAIL timeout early: got entering=%0d err=%0d entry_val=%0d want 1/0/7", bus.entering, bus.err, bus.entry_val); end
      cycle();
      checks++; if (bus.err !== 1'b1 || bus.entering !== 1'b0 || bus.entry_val !== 7'd0 || bus.cmd_valid !== 1'b0) begin failures++;
         $display("[TB] FAIL timeout fire: got err=%0d entering=%0d entry_val=%0d valid=%0d want 1/0/0/0", bus.err, bus.entering, bus.entry_val, bus.cmd_valid); end
      cycle();
      checks++; if (bus.err !== 1'b0 || bus.cmd_valid !== 1'b0) begin failures++;
         $display("[TB] FAIL timeout after: got err=%0d valid=%0d want 0/0", bus.err, bus.cmd_valid); end
   endtask

   task automatic test_back_to_back();
      bus.cmd_ready = 1'b0;
      applyStimulus(10'd10, 1'b0);
      checks++; if (bus.cmd_valid !== 1'b1 || bus.cmd_op !== 3'd1) begin failures++;
         $display("[TB] FAIL buf fwd: got valid=%0d op=%0d want 1/1", bus.cmd_valid, bus.cmd_op); end
      applyStimulus(10'd12, 1'b0);
      checks++; if (bus.err !== 1'b0 || bus.cmd_op !== 3'd1) begin failures++;
         $display("[TB] FAIL buf store: got err=%0d op=%0d want 0/1", bus.err, bus.cmd_op); end
      applyStimulus(10'd13, 1'b0);
      checks++; if (bus.err !== 1'b1) begin failures++;
         $display("[TB] FAIL buf full: got err=%0d want 1", bus.err); end
      applyStimulus(10'd14, 1'b0);
      checks++; if (bus.err !== 1'b0 || bus.cmd_valid !== 1'b1 || bus.cmd_op !== 3'd1) begin failures++;
         $display("[TB] FAIL buf stop_replace: got err=%0d valid=%0d op=%0d want 0/1/1", bus.err, bus.cmd_valid, bus.cmd_op); end
      bus.cmd_ready = 1'b1;
      cycle();
      checks++; if (bus.cmd_valid !== 1'b0 || bus.cmd_op !== 3'd0) begin failures++;
         $display("[TB] FAIL buf gap: got valid=%0d op=%0d want 0/0", bus.cmd_valid, bus.cmd_op); end
      cycle();
      checks++; if (bus.cmd_valid !== 1'b1 || bus.cmd_op !== 3'd5 || bus.cmd_arg !== 7'd0) begin failures++;
         $display("[TB] FAIL buf stop_issue: got valid=%0d op=%0d arg=%0d want 1/5/0", bus.cmd_valid, bus.cmd_op, bus.cmd_arg); end
      cycle();
      cycle();
      checks++; if (bus.cmd_valid !== 1'b0) begin failures++;
         $display("[TB] FAIL buf empty: got valid=%0d want 0", bus.cmd_valid); end
      applyStimulus(10'd11, 1'b0);
      checks++; if (bus.cmd_valid !== 1'b1 || bus.cmd_op !== 3'd2) begin failures++;
         $display("[TB] FAIL hs bwd: got valid=%0d op=%0d want 1/2", bus.cmd_valid, bus.cmd_op); end
      applyStimulus(10'd13, 1'b0);
      checks++; if (bus.cmd_valid !== 1'b0) begin failures++;
         $display("[TB] FAIL hs edge_drop: got valid=%0d want 0", bus.cmd_valid); end
      cycle();
      checks++; if (bus.cmd_valid !== 1'b1 || bus.cmd_op !== 3'd4) begin failures++;
         $display("[TB] FAIL hs right: got valid=%0d op=%0d want 1/4", bus.cmd_valid, bus.cmd_op); end
      cycle();
      checks++; if (bus.cmd_valid !== 1'b0) begin failures++;
         $display("[TB] FAIL hs final: got valid=%0d want 0", bus.cmd_valid); end
   endtask

   task automatic test_reset_mid_command();
      bus.cmd_ready = 1'b0;
      applyStimulus(10'd14, 1'b0);
      applyStimulus(10'd10, 1'b0);
      checks++; if (bus.cmd_valid !== 1'b1 || bus.cmd_op !== 3'd5) begin failures++;
         $display("[TB] FAIL rst_mid setup: got valid=%0d op=%0d want 1/5", bus.cmd_valid, bus.cmd_op); end
      reset = 1'b1;
      cycle();
      checks++; if (bus.cmd_valid !== 1'b0 || bus.cmd_op !== 3'd0 || bus.entering !== 1'b0 || bus.err !== 1'b0) begin failures++;
         $display("[TB] FAIL rst_mid outputs: got valid=%0d op=%0d entering=%0d err=%0d want 0/0/0/0", bus.cmd_valid, bus.cmd_op, bus.entering, bus.err); end
      reset = 1'b0;
      bus.cmd_ready = 1'b1;
      cycle();
      cycle();
      checks++; if (bus.cmd_valid !== 1'b0 || bus.cmd_op !== 3'd0) begin failures++;
         $display("[TB] FAIL rst_mid pending: got valid=%0d op=%0d want 0/0", bus.cmd_valid, bus.cmd_op); end
   endtask

   // Scenario sequence and summary
   initial begin
      reset          = 1'b1;
      bus.key_flag   = 1'b0;
      bus.key_num    = 10'd0;
      bus.cmd_ready  = 1'b1;
      bus50.key_flag = 1'b0;
      bus50.key_num  = 10'd0;
      bus50.cmd_ready = 1'b1;
      test_reset();
      test_speed_entry();
      test_motion_keys();
      test_digit_limit();
      test_speed_max();
      test_timeout();
      test_back_to_back();
      test_reset_mid_command();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
